// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one operation in flight, result presented on a one-cycle writeback strobe.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1Val,
  input  logic [XLEN-1:0] rs2Val,
  input  logic [4:0]      rdAddr,
  output logic            busy,
  output logic            wbValid,
  output logic [4:0]      wbAddr,
  output logic [XLEN-1:0] wbData
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [4:0]      count;
  logic [2:0]      op;
  logic [4:0]      rd;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] op_b;

  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_by_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_result;

  // Decode of the incoming request, only meaningful while IDLE with start high.
  always_comb begin
    is_div   = funct3[2];
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010: a_signed = 1'b1;
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase
    a_neg = a_signed & rs1Val[XLEN-1];
    b_neg = b_signed & rs2Val[XLEN-1];
    a_mag = a_neg ? (~rs1Val + 1'b1) : rs1Val;
    b_mag = b_neg ? (~rs2Val + 1'b1) : rs2Val;

    div_by_zero = is_div && (rs2Val == '0);
    div_ovf     = is_div && !funct3[0] && (rs1Val == SIGN_MIN) && (rs2Val == '1);
    special     = div_by_zero || div_ovf;

    special_result = '0;
    if (div_by_zero)
      special_result = funct3[1] ? rs1Val : '1;
    else if (div_ovf)
      special_result = funct3[1] ? '0 : SIGN_MIN;
  end

  logic [XLEN:0]   mul_add;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_trial;
  logic            div_borrow;
  logic [XLEN-1:0] iter_hi;
  logic [XLEN-1:0] iter_lo;

  // One iteration step. Multiply: acc_lo holds the multiplier and shifts out
  // toward the LSB while product bits shift in. Divide: acc_hi is the partial
  // remainder and acc_lo shifts the dividend out and quotient bits in.
  always_comb begin
    mul_add    = acc_lo[0] ? {1'b0, op_b} : '0;
    mul_sum    = {1'b0, acc_hi} + mul_add;
    div_trial  = {acc_hi, acc_lo[XLEN-1]} - {1'b0, op_b};
    div_borrow = div_trial[XLEN];
    if (op[2]) begin
      iter_hi = div_borrow ? {acc_hi[XLEN-2:0], acc_lo[XLEN-1]} : div_trial[XLEN-1:0];
      iter_lo = {acc_lo[XLEN-2:0], ~div_borrow};
    end else begin
      iter_hi = mul_sum[XLEN:1];
      iter_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] product_fixed;
  logic [XLEN-1:0]   quot_fixed;
  logic [XLEN-1:0]   rem_fixed;
  logic [XLEN-1:0]   fix_result;

  // Sign correction and result select for the FIX state.
  always_comb begin
    product       = {acc_hi, acc_lo};
    product_fixed = neg_q ? (~product + 1'b1) : product;
    quot_fixed    = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    rem_fixed     = neg_r ? (~acc_hi + 1'b1) : acc_hi;
    case (op)
      3'b000:                 fix_result = product_fixed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = product_fixed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quot_fixed;
      default:                fix_result = rem_fixed;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      op      <= '0;
      rd      <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      op_b    <= '0;
      busy    <= 1'b0;
      wbValid <= 1'b0;
      wbAddr  <= '0;
      wbData  <= '0;
    end else begin
      wbValid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op    <= funct3;
            rd    <= rdAddr;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            count <= '0;
            busy  <= 1'b1;
            if (special) begin
              // Divide corner cases skip iteration and write back immediately.
              state   <= DONE;
              wbValid <= 1'b1;
              wbAddr  <= rdAddr;
              wbData  <= special_result;
            end else begin
              state  <= RUN;
              acc_hi <= '0;
              acc_lo <= is_div ? a_mag : b_mag;
              op_b   <= is_div ? b_mag : a_mag;
            end
          end
        end
        RUN: begin
          acc_hi <= iter_hi;
          acc_lo <= iter_lo;
          count  <= count + 5'd1;
          if (count == 5'd31)
            state <= FIX;
        end
        FIX: begin
          wbData  <= fix_result;
          wbAddr  <= rd;
          wbValid <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
